// File: rtl/muldiv_pkg.sv
// Shared opcodes, ALU opcodes and FSM encoding for the muldiv sequencer.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero-operand early completion).
package muldiv_pkg;

    localparam logic [1:0] MD_MUL   = 2'b00;
    localparam logic [1:0] MD_MULHU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_REMU  = 2'b11;

    localparam logic [3:0] OPE_ADD = 4'b0010;
    localparam logic [3:0] OPE_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Divide ops live in the upper half of the opcode space.
    function automatic logic is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One shift-add / restoring-divide iteration.
// Computes next {acc/rem, mq} from the current state and the ALU return.
module muldiv_step #(
    parameter int N = 32
) (
    input  logic         div,
    input  logic [N-1:0] hi,
    input  logic [N-1:0] mq,
    input  logic [N-1:0] alu_res_i,
    input  logic         alu_c_i,
    output logic [N-1:0] sh,
    output logic [N-1:0] hi_nxt,
    output logic [N-1:0] mq_nxt
);

    logic take;

    // Next-state selection for multiply (add/shift) or divide (sub/restore).
    always_comb begin
        sh     = {hi[N-2:0], mq[N-1]};
        take   = hi[N-1] | alu_c_i;
        hi_nxt = hi;
        mq_nxt = mq;
        if (div) begin
            hi_nxt = take ? alu_res_i : sh;
            mq_nxt = {mq[N-2:0], take};
        end else if (mq[0]) begin
            hi_nxt = {alu_c_i, alu_res_i[N-1:1]};
            mq_nxt = {alu_res_i[0], mq[N-1:1]};
        end else begin
            hi_nxt = {1'b0, hi[N-1:1]};
            mq_nxt = {hi[0], mq[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer sharing the superalu.
// Optional feature macro: MULDIV_EARLY_OUT_EN (zero operand skips RUN).
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [1:0]   req_op_i,
    input  logic [N-1:0] req_a_i,
    input  logic [N-1:0] req_b_i,
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic [N-1:0] resp_res_o,
    output logic         resp_dbz_o,
    output logic         busy_o,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_ope_o,
    output logic         alu_negzero_o,
    input  logic [N-1:0] alu_res_i,
    input  logic         alu_c_i
);

    localparam int CW = $clog2(N);

    state_t         state;
    logic [1:0]     op;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   hi;
    logic [N-1:0]   mq;
    logic [N-1:0]   opnd;
    logic [N-1:0]   sh;
    logic [N-1:0]   hi_nxt;
    logic [N-1:0]   mq_nxt;
    logic [N-1:0]   res_nxt;
    logic           div;

    assign div = is_div(op);

    muldiv_step #(.N(N)) u_step (
        .div       (div),
        .hi        (hi),
        .mq        (mq),
        .alu_res_i (alu_res_i),
        .alu_c_i   (alu_c_i),
        .sh        (sh),
        .hi_nxt    (hi_nxt),
        .mq_nxt    (mq_nxt)
    );

    // Result picked from the state the final iteration is about to write.
    always_comb begin
        unique case (op)
            MD_MULHU, MD_REMU: res_nxt = hi_nxt;
            default:           res_nxt = mq_nxt;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic         zero_hit;
    logic [N-1:0] zero_res;

    // Zero-operand shortcut, matching what the full iteration would produce.
    always_comb begin
        zero_hit = is_div(req_op_i) ? (req_b_i == '0)
                                    : (req_a_i == '0) || (req_b_i == '0);
        unique case (req_op_i)
            MD_DIVU: zero_res = '1;
            MD_REMU: zero_res = req_a_i;
            default: zero_res = '0;
        endcase
    end
`endif

    // Sequencer FSM, iteration datapath and registered response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            op         <= MD_MUL;
            cnt        <= '0;
            hi         <= '0;
            mq         <= '0;
            opnd       <= '0;
            resp_res_o <= '0;
            resp_dbz_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op    <= req_op_i;
                        cnt   <= '0;
                        hi    <= '0;
                        state <= RUN;
                        if (is_div(req_op_i)) begin
                            mq   <= req_a_i;
                            opnd <= req_b_i;
                        end else begin
                            mq   <= req_b_i;
                            opnd <= req_a_i;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        if (zero_hit) begin
                            state      <= DONE;
                            resp_res_o <= zero_res;
                            resp_dbz_o <= is_div(req_op_i);
                        end
`endif
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    mq  <= mq_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        state      <= DONE;
                        resp_res_o <= res_nxt;
                        resp_dbz_o <= div & (opnd == '0);
                    end
                end
                DONE: begin
                    if (resp_ready_i) begin
                        state      <= IDLE;
                        resp_res_o <= '0;
                        resp_dbz_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake flags and ALU drive decoded from the state register.
    always_comb begin
        req_ready_o   = (state == IDLE);
        busy_o        = (state == RUN) || (state == DONE);
        resp_valid_o  = (state == DONE);
        alu_negzero_o = 1'b0;
        alu_a_o       = '0;
        alu_b_o       = '0;
        alu_ope_o     = OPE_ADD;
        if (state == RUN) begin
            alu_a_o   = div ? sh : hi;
            alu_b_o   = opnd;
            alu_ope_o = div ? OPE_SUB : OPE_ADD;
        end
    end

endmodule
